// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a byte FIFO.
//
// Optional feature macro: UART_TX_IRQ_EN. When it is defined, the CTRL
// register (irq_en) and a registered level interrupt are built. Without it,
// irq is tied to 0, CTRL reads 0 and CTRL writes are ignored.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset_n    asynchronous active-low reset
//   sel        access targets this block (decoded upstream)
//   we         write strobe; a write happens on a clk edge with sel & we
//   addr[1:0]  word offset: 0 DATA, 1 STATUS, 2 DIVISOR, 3 CTRL
//   wdata[31:0] write data
//   rdata[31:0] combinational read data, 0 when !sel
//   txd        serial output, idle high, driven from a flop
//   irq        interrupt request (0 unless UART_TX_IRQ_EN)
//   dbg_state  current transmitter FSM state (IDLE=0 START=1 DATA=2 STOP=3)
//
// Bus handshake: there is no backpressure. A cycle with sel & we is a
// complete write on that clk edge; a cycle with sel & !we is a read whose
// data is valid combinationally in the same cycle. Reads have no side
// effects. A DATA write to a full FIFO is not stalled: it is dropped and
// flagged through the sticky overflow bit.
//
// Register map:
//   DATA    (0) W: push wdata[7:0]; R: 0
//   STATUS  (1) R: {count[11:8], overflow[3], empty[2], full[1], busy[0]}
//               W: writing 1 to bit3 clears overflow (a new overflow wins)
//   DIVISOR (2) R/W 16-bit; effective divisor is max(DIVISOR, 2), sampled
//               when a frame starts
//   CTRL    (3) bit0 irq_en (only with UART_TX_IRQ_EN)
module uart_tx_mmio #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq,
  output logic [1:0]  dbg_state
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DIV_RST = 16'(CLK_HZ / BAUD);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t state, state_d;

  // FIFO storage and bookkeeping
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_d;
  logic          full, empty;
  logic          push, pop;

  // Registers
  logic [15:0] div_reg;
  logic [15:0] eff_div;
  logic [15:0] frame_div;
  logic        overflow;

  // Transmit datapath
  logic [7:0]  shift;
  logic [2:0]  bit_idx;
  logic [15:0] baud_cnt;
  logic        tick;

  // Bus decode
  logic wr_en, data_wr, status_wr, div_wr, ovf_evt;

  assign wr_en     = sel & we;
  assign data_wr   = wr_en & (addr == 2'd0);
  assign status_wr = wr_en & (addr == 2'd1);
  assign div_wr    = wr_en & (addr == 2'd2);

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A full FIFO still accepts a byte when the transmitter pops in the same
  // cycle, so only a push with no room and no pop is an overflow.
  assign push    = data_wr & (~full | pop);
  assign ovf_evt = data_wr & full & ~pop;

  assign eff_div = (div_reg < 16'd2) ? 16'd2 : div_reg;
  assign tick    = (baud_cnt == frame_div - 16'd1);

  assign dbg_state = state;

  always_comb begin
    count_d = count;
    case ({push, pop})
      2'b10:   count_d = count + 1'b1;
      2'b01:   count_d = count - 1'b1;
      default: count_d = count;
    endcase
  end

  // Next-state logic. The head byte is popped on the IDLE->START edge.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: if (tick) state_d = S_DATA;
      S_DATA:  if (tick && (bit_idx == 3'd7)) state_d = S_STOP;
      S_STOP:  if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg  <= DIV_RST;
      overflow <= 1'b0;
    end else begin
      if (div_wr) div_reg <= wdata[15:0];
      if (ovf_evt)                     overflow <= 1'b1;
      else if (status_wr && wdata[3])  overflow <= 1'b0;
    end
  end

  // Baud counter restarts on every state change so each state gets whole
  // bit periods; in DATA it wraps on each tick for the next bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt  <= '0;
      frame_div <= 16'd2;
      shift     <= '0;
      bit_idx   <= '0;
      txd       <= 1'b1;
    end else begin
      if ((state_d != state) || tick || (state == S_IDLE)) baud_cnt <= '0;
      else                                                 baud_cnt <= baud_cnt + 16'd1;

      if (pop) begin
        shift     <= mem[rd_ptr];
        frame_div <= eff_div;
      end else if ((state == S_DATA) && tick) begin
        shift <= {1'b0, shift[7:1]};
      end

      if (state != S_DATA) bit_idx <= '0;
      else if (tick)       bit_idx <= bit_idx + 3'd1;

      // txd follows the current state one cycle later, from a flop.
      case (state)
        S_START: txd <= 1'b0;
        S_DATA:  txd <= shift[0];
        default: txd <= 1'b1;
      endcase
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en, irq_en_d;

  assign irq_en_d = (wr_en && (addr == 2'd3)) ? wdata[0] : irq_en;

  // Computed from next-cycle values so a DATA write drops irq right away.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      irq_en <= irq_en_d;
      irq    <= irq_en_d & (count_d == '0) & (state_d == S_IDLE);
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (addr)
        2'd1: rdata = {20'd0, 4'(count), 4'd0, overflow, empty, full,
                       (state != S_IDLE)};
        2'd2: rdata = {16'd0, div_reg};
`ifdef UART_TX_IRQ_EN
        2'd3: rdata = {31'd0, irq_en};
`endif
        default: rdata = 32'd0;
      endcase
    end
  end

  logic unused_wdata;
  assign unused_wdata = &{1'b0, wdata[31:16]};

endmodule

// File: tb/tb_uart_tx_mmio.sv
`timescale 1ns/1ps
module tb_uart_tx_mmio;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        txd;
  logic        irq;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_mmio #(
    .CLK_HZ(50000000),
    .BAUD(115200),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sel(sel),
    .we(we),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .txd(txd),
    .irq(irq),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_fail = 0;
  // Each entry is {bit period in cycles, byte}, pushed when a byte is written.
  logic [23:0] exp_q[$];
  int start_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference rule: a frame uses max(DIVISOR, 2) cycles per bit.
  task automatic exp_push(input int div, input logic [7:0] b);
    int eff;
    eff = (div < 2) ? 2 : div;
    exp_q.push_back({16'(eff), b});
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    sel = 1'b0;
  endtask

  task automatic wait_idle();
    logic [31:0] r;
    int k;
    k = 0;
    do begin
      bus_read(2'd1, r);
      k++;
    end while (!((r[0] == 1'b0) && (r[2] == 1'b1)) && (k < 20000));
    if (k >= 20000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles, status 0x%08h", k, r);
    end
    repeat (3) @(posedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [23:0] ent;
    logic [9:0]  bits;
    int d, k;
    bit aborted, bad;
    forever begin
      @(negedge clk);
      if (reset_n && (txd === 1'b0)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_start: txd fell at cycle %0d with no byte expected", cyc);
          k = 0;
          while ((txd === 1'b0) && (k < 20000)) begin
            @(negedge clk);
            k++;
          end
        end else begin
          ent = exp_q.pop_front();
          d = int'(ent[23:8]);
          bits = {1'b1, ent[7:0], 1'b0};
          start_q.push_back(cyc);
          aborted = 1'b0;
          for (int b = 0; b < 10 && !aborted; b++) begin
            bad = 1'b0;
            for (int c = 0; c < d && !aborted; c++) begin
              if (!((b == 0) && (c == 0))) @(negedge clk);
              if (!reset_n)               aborted = 1'b1;
              else if (txd !== bits[b])   bad = 1'b1;
            end
            if (!aborted) begin
              n_cmp++;
              if (bad) begin
                n_fail++;
                $display("FAIL frame_bit: byte 0x%02h bit %0d not held at %0d for %0d cycles", ent[7:0], b, bits[b], d);
              end
            end
          end
          if (!aborted) begin
            @(negedge clk);
            if (reset_n) begin
              n_cmp++;
              if (txd !== 1'b1) begin
                n_fail++;
                $display("FAIL frame_end: byte 0x%02h txd=%0d after 10 bits, required 1", ent[7:0], txd);
              end
            end
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    logic [7:0]  b;
    int first, last, diff, d, n;

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Reset defaults
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    bus_read(2'd1, r); check("rst_status", r, 32'h4);
    bus_read(2'd2, r); check("rst_divisor", r, 32'd434);
    bus_read(2'd0, r); check("data_read", r, 32'd0);
    bus_read(2'd3, r); check("rst_ctrl", r, 32'd0);
    @(negedge clk);
    addr = 2'd2; sel = 1'b0;
    #1 check("rdata_nosel", rdata, 32'd0);

    // Single byte, start latency and busy length
    bus_write(2'd2, 32'd4);
    exp_push(4, 8'hA5);
    bus_write(2'd0, 32'hA5);
    check("lat_edge0", {31'd0, txd}, 32'd1);
    @(posedge clk); #1 check("lat_edge1", {31'd0, txd}, 32'd1);
    @(posedge clk); #1 check("lat_edge2", {31'd0, txd}, 32'd0);
    repeat (38) @(posedge clk);
    bus_read(2'd1, r); check("busy_cycle40", {31'd0, r[0]}, 32'd1);
    bus_read(2'd1, r); check("busy_cycle41", {31'd0, r[0]}, 32'd0);
    wait_idle();

    // FIFO fill and overflow
    bus_write(2'd2, 32'd100);
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < 9) exp_push(100, b);
      bus_write(2'd0, {24'd0, b});
    end
    bus_read(2'd1, r); check("ovf_status", r, 32'h0000080B);
    bus_write(2'd1, 32'h8);
    bus_read(2'd1, r); check("ovf_clear", r, 32'h00000803);
    wait_idle();
    bus_read(2'd1, r); check("ovf_drained", r, 32'h4);

    // Back-to-back frames
    bus_write(2'd2, 32'd2);
    start_q.delete();
    exp_push(2, 8'h00);
    exp_push(2, 8'hFF);
    bus_write(2'd0, 32'h00);
    bus_write(2'd0, 32'hFF);
    first = -1; last = -1;
    for (int i = 0; i < 60; i++) begin
      bus_read(2'd1, r);
      if (r[0]) begin
        if (first < 0) first = i;
        last = i;
      end
    end
    check("b2b_busy_span", 32'(last - first + 1), 32'd41);
    wait_idle();
    diff = (start_q.size() == 2) ? (start_q[1] - start_q[0]) : -1;
    check("b2b_start_gap", 32'(diff), 32'd21);

    // Divisor clamp and mid-frame divisor change
    bus_write(2'd2, 32'd0);
    bus_read(2'd2, r); check("div_raw0", r, 32'd0);
    exp_push(0, 8'h3C);
    bus_write(2'd0, 32'h3C);
    repeat (6) @(posedge clk);
    bus_write(2'd2, 32'd8);
    bus_read(2'd2, r); check("div_raw8", r, 32'd8);
    exp_push(8, 8'hC3);
    bus_write(2'd0, 32'hC3);
    wait_idle();

    // Randomized traffic
    for (int it = 0; it < 6; it++) begin
      d = $urandom_range(0, 6);
      bus_write(2'd2, 32'(d));
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom_range(0, 255));
        exp_push(d, b);
        bus_write(2'd0, {24'd0, b});
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      wait_idle();
      bus_read(2'd1, r); check("rand_idle_status", r, 32'h4);
    end

    // Reset in the middle of a frame
    bus_write(2'd2, 32'd10);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_push(10, b);
      bus_write(2'd0, {24'd0, b});
    end
    repeat (30) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("rst_mid_txd", {31'd0, txd}, 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    bus_read(2'd1, r); check("rst_mid_status", r, 32'h4);
    bus_read(2'd2, r); check("rst_mid_divisor", r, 32'd434);
    repeat (30) @(posedge clk);
    check("rst_mid_txd_idle", {31'd0, txd}, 32'd1);

    // CTRL and irq
    bus_write(2'd2, 32'd3);
    bus_write(2'd3, 32'd1);
    bus_read(2'd3, r);
`ifdef UART_TX_IRQ_EN
    check("ctrl_read", r, 32'd1);
    check("irq_idle", {31'd0, irq}, 32'd1);
    exp_push(3, 8'h5A);
    bus_write(2'd0, 32'h5A);
    check("irq_after_write", {31'd0, irq}, 32'd0);
    wait_idle();
    check("irq_idle_again", {31'd0, irq}, 32'd1);
`else
    check("ctrl_read", r, 32'd0);
    check("irq_idle", {31'd0, irq}, 32'd0);
    exp_push(3, 8'h5A);
    bus_write(2'd0, 32'h5A);
    check("irq_after_write", {31'd0, irq}, 32'd0);
    wait_idle();
    check("irq_idle_again", {31'd0, irq}, 32'd0);
`endif

    repeat (5) @(posedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter with a byte FIFO. It sits on the CPU's I/O region, alongside the LED/HEX registers, and consumes CPU store traffic. The top-level address decode asserts `sel`. Stored bytes are serialised 8N1 on `txd` at a programmable baud rate. It gives the firmware a debug/console output path.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz; used only for the divisor reset value.
- BAUD, 115200, default baud rate; divisor reset value = CLK_HZ/BAUD (integer division, 434 at defaults).
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, ≥2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- sel  input  1  access targets this block (I/O region decoded upstream).
- we  input  1  write strobe; a write occurs on a clk edge with sel & we.
- addr  input  2  register offset (word index): 0 DATA, 1 STATUS, 2 DIVISOR, 3 CTRL.
- wdata  input  32  write data.
- rdata  output  32  read data; combinational from addr; 0 when !sel.
- txd  output  1  serial output; idle high.
- irq  output  1  interrupt request (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): `txd`=1, `irq`=0, FIFO empty, state IDLE, DIVISOR=CLK_HZ/BAUD, CTRL=0, overflow=0.
- DATA write (offset 0): pushes wdata[7:0] into the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and the sticky overflow bit is set.
  - A push and a pop in the same cycle while full: the push is accepted and the count is unchanged.
- DATA read returns 0.
- STATUS read (offset 1) fields:
  - bit0: busy (state != IDLE)
  - bit1: full
  - bit2: empty
  - bit3: overflow
  - bits[11:8]: FIFO count (0..FIFO_DEPTH)
  - all other bits 0
- STATUS write: writing 1 to bit3 clears overflow. If an overflow event occurs in the same cycle, set wins.
- DIVISOR (offset 2): 16-bit R/W register, wdata[15:0]; upper read bits are 0.
  - Effective divisor = max(DIVISOR, 2).
  - The effective value is latched into a frame divisor when a frame starts.
  - A mid-frame write does not affect the current frame.
- CTRL (offset 3): bit0 irq_en; other bits read 0.
- Baud counter: counts from 0 to div-1, emitting a one-cycle bit tick at div-1, then wraps to 0. It is reset to 0 on every state entry.
- FSM:
  - IDLE: `txd`=1. If the FIFO is not empty, pop the head byte into the shift register, latch the divisor, and go to START on the same edge.
  - START: `txd`=0 for one bit period, then go to DATA with bit index 0.
  - DATA: `txd`=shift[0]. On each tick, shift right and increment the index. After the 8th bit (LSB first), go to STOP.
  - STOP: `txd`=1 for one bit period. On the tick, go to IDLE.
- Latency: a byte written into an empty FIFO while IDLE produces the falling start edge exactly 2 clk edges after the write edge (pop edge, then `txd` registered).
- Frame length: exactly 10*div cycles.
- Back-to-back frames: STOP→IDLE→START adds exactly 1 idle cycle between frames.
- `txd` is driven from a flop (glitch-free).
- Reset mid-frame: `txd` returns to 1 immediately; the FIFO is flushed.

Optional Feature:
- Macro: UART_TX_IRQ_EN.
- Defined: `irq` is registered and equals irq_en & empty & (state==IDLE). It is level-sensitive and deasserts the cycle after a DATA write.
- Undefined: `irq` is constant 0, the CTRL register is not implemented, and offset 3 reads 0 with writes ignored.

Test Plan:
- Reset defaults: after reset_n release, read STATUS → 0x00000004; DIVISOR → 434; `txd`=1.
- Single byte: DIVISOR=4, write DATA 0xA5.
  - Required: start bit 2 edges later.
  - Required: `txd` sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - Required: busy clears after 40 cycles.
- FIFO fill/overflow: DIVISOR=100, write 10 bytes in consecutive cycles.
  - Required: first byte popped immediately, 8 queued, 10th dropped.
  - Required: STATUS count=8, full=1, overflow=1.
  - Required: writing 0x8 to STATUS clears overflow.
- Back-to-back: DIVISOR=2, write 0x00 then 0xFF.
  - Required: frames 20 cycles each, separated by exactly 1 idle-high cycle.
  - Required: total busy span 41 cycles.
- Divisor clamp and mid-frame change: DIVISOR=0 gives 2-cycle bits. Writing DIVISOR=8 during a frame leaves the current frame at 2-cycle bits and the next frame at 8-cycle bits.
- Reset mid-frame and irq: assert reset_n low during DATA bits.
  - Required: `txd`=1 immediately; FIFO empty after release.
  - Required (with UART_TX_IRQ_EN, CTRL=1): irq=1 while idle and empty, 0 the cycle after a DATA write.
